// File: rtl/aq_djpeg_zigzag_scan_if.sv
// Bus bundle for the zigzag scan buffer: natural-order coefficient writes in,
// zigzag-order coefficient reads out, plus bank status and block side info.
interface aq_djpeg_zigzag_scan_if #(
  parameter int DATA_W = 16
);
  logic                     DataInit;
  logic                     DataInEnable;
  logic [5:0]               DataInAddress;
  logic [2:0]               DataInColor;
  logic signed [DATA_W-1:0] DataIn;
  logic                     DataInIdle;
  logic                     DataOutEnable;
  logic                     DataOutRead;
  logic [5:0]               DataOutAddress;
  logic signed [DATA_W-1:0] DataOut;
  logic [2:0]               DataOutColor;
  logic [6:0]               DataOutEob;

  modport master (
    output DataInit, DataInEnable, DataInAddress, DataInColor, DataIn,
    output DataOutRead, DataOutAddress,
    input  DataInIdle, DataOutEnable, DataOut, DataOutColor, DataOutEob
  );

  modport slave (
    input  DataInit, DataInEnable, DataInAddress, DataInColor, DataIn,
    input  DataOutRead, DataOutAddress,
    output DataInIdle, DataOutEnable, DataOut, DataOutColor, DataOutEob
  );
endinterface

// File: rtl/aq_djpeg_zigzag_scan.sv
// Double-buffered 8x8 coefficient store: blocks are written in raster order and
// read back in JPEG zigzag order, with per-block color tag and end-of-block.
module aq_djpeg_zigzag_scan #(
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  aq_djpeg_zigzag_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // Zigzag position -> natural (row*8+col) index.
  localparam logic [5:0] ZZ_TAB [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  // Natural index -> zigzag position (inverse of ZZ_TAB).
  localparam logic [5:0] ZZINV_TAB [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  state_t     count, countNext;
  logic       wb, wbNext;
  logic       rb, rbNext;
  logic [6:0] runEob, runEobNext;
  logic [2:0] runColor, runColorNext;
  logic [6:0] bankEob   [2];
  logic [2:0] bankColor [2];

  logic signed [DATA_W-1:0] ram [2][64];
  logic signed [DATA_W-1:0] dataOut_p1;

  logic wrFire;
  logic wrDone;
  logic rdDone;

  // Index 0 restarts the running EOB so a new block never inherits the old one.
  function automatic logic [6:0] eobUpdate(
    input logic [6:0]               cur,
    input logic [5:0]               addr,
    input logic signed [DATA_W-1:0] data
  );
    logic [6:0] cand;
    cand = {1'b0, ZZINV_TAB[addr]} + 7'd1;
    if (addr == 6'd0)
      return (data != '0) ? 7'd1 : 7'd0;
    else if ((data != '0) && (cand > cur))
      return cand;
    else
      return cur;
  endfunction

  assign bus.DataInIdle    = (count != S_FULL);
  assign bus.DataOutEnable = (count != S_EMPTY);
  assign bus.DataOutColor  = bankColor[rb];
  assign bus.DataOutEob    = bankEob[rb];
  assign bus.DataOut       = dataOut_p1;

  assign wrFire = bus.DataInEnable && bus.DataInIdle;
  assign wrDone = wrFire && (bus.DataInAddress == 6'd63);
  assign rdDone = bus.DataOutRead && bus.DataOutEnable && (bus.DataOutAddress == 6'd63);

  always_comb begin
    countNext    = count;
    wbNext       = wb;
    rbNext       = rb;
    runEobNext   = runEob;
    runColorNext = runColor;

    if (wrFire) begin
      runEobNext = eobUpdate(runEob, bus.DataInAddress, bus.DataIn);
      if (bus.DataInAddress == 6'd0)
        runColorNext = bus.DataInColor;
    end
    if (wrDone) wbNext = ~wb;
    if (rdDone) rbNext = ~rb;

    // Simultaneous complete + release leaves occupancy unchanged.
    case (count)
      S_EMPTY: if (wrDone) countNext = S_ONE;
      S_ONE: begin
        if (wrDone && !rdDone)      countNext = S_FULL;
        else if (rdDone && !wrDone) countNext = S_EMPTY;
      end
      S_FULL:  if (rdDone) countNext = S_ONE;
      default: countNext = S_EMPTY;
    endcase

    if (bus.DataInit) begin
      countNext    = S_EMPTY;
      wbNext       = 1'b0;
      rbNext       = 1'b0;
      runEobNext   = 7'd0;
      runColorNext = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= S_EMPTY;
      wb           <= 1'b0;
      rb           <= 1'b0;
      runEob       <= 7'd0;
      runColor     <= 3'd0;
      bankEob[0]   <= 7'd0;
      bankEob[1]   <= 7'd0;
      bankColor[0] <= 3'd0;
      bankColor[1] <= 3'd0;
    end else begin
      count    <= countNext;
      wb       <= wbNext;
      rb       <= rbNext;
      runEob   <= runEobNext;
      runColor <= runColorNext;
      if (bus.DataInit) begin
        bankEob[0]   <= 7'd0;
        bankEob[1]   <= 7'd0;
        bankColor[0] <= 3'd0;
        bankColor[1] <= 3'd0;
      end else if (wrDone) begin
        bankEob[wb]   <= runEobNext;
        bankColor[wb] <= runColor;
      end
    end
  end

  // Write stage: coefficient storage, never cleared.
  always_ff @(posedge clk) begin
    if (wrFire && !bus.DataInit && !rst)
      ram[wb][bus.DataInAddress] <= bus.DataIn;
  end

  // Read stage p1: registered zigzag read from the current read bank.
  always_ff @(posedge clk) begin
    if (rst)
      dataOut_p1 <= '0;
    else if (bus.DataOutRead)
      dataOut_p1 <= ram[rb][ZZ_TAB[bus.DataOutAddress]];
  end

endmodule

// File: tb/tb_aq_djpeg_zigzag_scan.sv
// Scoreboard bench for the zigzag scan buffer: reads push expected data,
// a negedge monitor pops and compares whenever a read result is due.
module tb_aq_djpeg_zigzag_scan;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aq_djpeg_zigzag_scan_if #(.DATA_W(DATA_W)) bus ();
  aq_djpeg_zigzag_scan #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  int          checks = 0;
  int          failures = 0;
  logic [15:0] expQ [$];
  logic [15:0] expV;
  logic        pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Block content patterns by natural index.
  function automatic logic [15:0] pv(input int pat, input int i);
    case (pat)
      0: return 16'(i + 100);
      1: return (i == 9) ? 16'hFFFB : 16'h0000;
      2: return 16'(i * 3 - 50);
      3: return (i < 20) ? 16'(i + 1) : 16'h0000;
      4: return 16'd7777;
      5: return (i % 5 == 0) ? 16'(-(i + 1)) : 16'h0000;
      6: return (i % 7 == 3) ? 16'(i * 11) : 16'h0000;
      default: return 16'(i) ^ 16'h5A5A;
    endcase
  endfunction

  // Highest zigzag position holding a nonzero value, plus one.
  function automatic logic [6:0] eobOf(input int pat);
    for (int z = 63; z >= 0; z--)
      if (pv(pat, ZZ[z]) != 16'h0000) return 7'(z + 1);
    return 7'd0;
  endfunction

  always @(posedge clk) pend <= bus.DataOutRead;

  always @(negedge clk) begin
    if (pend) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=%0h required=none", $unsigned(bus.DataOut));
      end else begin
        expV = expQ.pop_front();
        check("dataOut", {16'b0, $unsigned(bus.DataOut)}, {16'b0, expV});
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    bus.DataInEnable = 1'b0;
    bus.DataOutRead  = 1'b0;
    bus.DataInit     = 1'b0;
  endtask

  task automatic setWrite(input int a, input logic [15:0] d, input logic [2:0] c);
    bus.DataInEnable  = 1'b1;
    bus.DataInAddress = 6'(a);
    bus.DataIn        = d;
    bus.DataInColor   = c;
  endtask

  task automatic setRead(input int pat, input int z);
    expQ.push_back(pv(pat, ZZ[z]));
    bus.DataOutRead    = 1'b1;
    bus.DataOutAddress = 6'(z);
  endtask

  task automatic writeRange(input int pat, input int lo, input int hi, input logic [2:0] c);
    for (int i = lo; i <= hi; i++) begin
      setWrite(i, pv(pat, i), c);
      cycle();
    end
  endtask

  task automatic readRange(input int pat, input int lo, input int hi);
    for (int z = lo; z <= hi; z++) begin
      setRead(pat, z);
      cycle();
    end
  endtask

  task automatic checkStatus(input string tag, input logic idle, input logic en,
                             input logic [2:0] col, input logic [6:0] eob);
    check({tag, "_idle"},  {31'b0, bus.DataInIdle},    {31'b0, idle});
    check({tag, "_en"},    {31'b0, bus.DataOutEnable}, {31'b0, en});
    check({tag, "_color"}, {29'b0, bus.DataOutColor},  {29'b0, col});
    check({tag, "_eob"},   {25'b0, bus.DataOutEob},    {25'b0, eob});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.DataInit       = 1'b0;
    bus.DataInEnable   = 1'b0;
    bus.DataInAddress  = 6'd0;
    bus.DataInColor    = 3'd0;
    bus.DataIn         = '0;
    bus.DataOutRead    = 1'b0;
    bus.DataOutAddress = 6'd0;

    // Reset state
    rst = 1'b1;
    repeat (3) cycle();
    checkStatus("reset", 1'b1, 1'b0, 3'd0, 7'd0);
    check("reset_dataOut", {16'b0, $unsigned(bus.DataOut)}, 32'd0);
    rst = 1'b0;
    cycle();

    // Index+100 block, color 2: full EOB
    writeRange(0, 0, 63, 3'd2);
    checkStatus("blk0", 1'b1, 1'b1, 3'd2, 7'd64);
    readRange(0, 0, 63);
    check("blk0_drained", {31'b0, bus.DataOutEnable}, 32'd0);

    // Single -5 at natural 9 -> zigzag 4
    writeRange(1, 0, 63, 3'd5);
    checkStatus("blk1", 1'b1, 1'b1, 3'd5, 7'd5);
    readRange(1, 0, 63);

    // Two blocks, third ignored while full
    writeRange(2, 0, 63, 3'd1);
    writeRange(3, 0, 63, 3'd3);
    checkStatus("full", 1'b0, 1'b1, 3'd1, eobOf(2));
    writeRange(4, 0, 63, 3'd6);
    checkStatus("ignored", 1'b0, 1'b1, 3'd1, eobOf(2));
    readRange(2, 0, 63);
    checkStatus("second", 1'b1, 1'b1, 3'd3, eobOf(3));
    readRange(3, 0, 63);
    check("second_drained", {31'b0, bus.DataOutEnable}, 32'd0);

    // Simultaneous completion and release
    writeRange(5, 0, 63, 3'd4);
    writeRange(6, 0, 62, 3'd7);
    readRange(5, 0, 62);
    setWrite(63, pv(6, 63), 3'd7);
    setRead(5, 63);
    cycle();
    checkStatus("swap", 1'b1, 1'b1, 3'd7, eobOf(6));
    readRange(6, 0, 63);
    check("swap_drained", {31'b0, bus.DataOutEnable}, 32'd0);

    // DataInit with a stored block and a partial one
    writeRange(0, 0, 63, 3'd2);
    writeRange(7, 0, 29, 3'd6);
    bus.DataInit = 1'b1;
    setWrite(30, 16'h1234, 3'd6);
    cycle();
    checkStatus("init", 1'b1, 1'b0, 3'd0, 7'd0);

    // Reset mid-block, then a clean block
    writeRange(7, 0, 29, 3'd6);
    rst = 1'b1;
    repeat (2) cycle();
    checkStatus("midrst", 1'b1, 1'b0, 3'd0, 7'd0);
    rst = 1'b0;
    cycle();
    writeRange(2, 0, 63, 3'd3);
    checkStatus("after_rst", 1'b1, 1'b1, 3'd3, eobOf(2));
    readRange(2, 0, 63);
    check("after_rst_drained", {31'b0, bus.DataOutEnable}, 32'd0);

    repeat (3) cycle();
    check("sb_empty", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aq_djpeg_zigzag_scan.md
AQ_DJPEG_ZIGZAG_SCAN -- requirements
Module: aq_djpeg_zigzag_scan

Interface
REQ-001 Parameter DATA_W, default 16: coefficient width in bits, used for DataIn and DataOut.
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 DataInit  input  1  one-cycle pulse; SHALL clear both banks, all pointers and all flags.
REQ-005 DataInEnable  input  1  write strobe for one coefficient in natural (raster) order.
REQ-006 DataInAddress  input  6  natural index 0..63 (row*8+col).
REQ-007 DataInColor  input  3  component tag, sampled on the write of index 0.
REQ-008 DataIn  input  DATA_W  quantized coefficient, two's complement.
REQ-009 DataInIdle  output  1  high when a free bank can accept writes.
REQ-010 DataOutEnable  output  1  high when at least one complete bank is readable.
REQ-011 DataOutRead  input  1  read strobe.
REQ-012 DataOutAddress  input  6  zigzag index 0..63 to read.
REQ-013 DataOut  output  DATA_W  coefficient at natural index ZZ(DataOutAddress), one cycle after the strobe.
REQ-014 DataOutColor  output  3  color tag of the current read bank.
REQ-015 DataOutEob  output  7  for the read bank: 1 + highest zigzag index holding a nonzero value; 0 if all coefficients are zero.

Function
REQ-016 Storage SHALL be 2 banks x 64 x DATA_W, with a write-bank pointer WB and a read-bank pointer RB, each 1 bit.
REQ-017 Bank state SHALL be tracked by Count in the range 0..2: S_EMPTY (0), S_ONE (1), S_FULL (2).
REQ-018 DataInIdle SHALL equal (Count != 2); DataOutEnable SHALL equal (Count != 0).
REQ-019 A write SHALL occur when DataInEnable and DataInIdle are both high; any write while DataInIdle is low SHALL be ignored with no state change.
REQ-020 A write SHALL store DataIn at [WB][DataInAddress]; writes may arrive in any order.
REQ-021 A write to index 63 SHALL complete the bank as follows:
- latch the color and EOB for WB;
- toggle WB;
- increment Count.
REQ-022 EOB tracking SHALL work as follows:
- a write of index 0 sets the running EOB to (DataIn != 0 ? 1 : 0);
- any other nonzero write sets running EOB = max(running EOB, ZZINV(DataInAddress)+1);
- ZZINV is the natural-to-zigzag map.
REQ-023 ZZ / ZZINV SHALL be the ITU-T T.81 Figure A.6 zigzag order. Examples for ZZ:
- ZZ(0)=0, ZZ(1)=1, ZZ(2)=8, ZZ(3)=16;
- ZZ(4)=9, ZZ(5)=2, ZZ(6)=3, ZZ(63)=63.
REQ-024 Reads SHALL be synchronous: DataOut is registered from [RB][ZZ(DataOutAddress)] and valid in the cycle after DataOutRead; it holds its value when no read is issued.
REQ-025 A read of address 63 while DataOutEnable is high SHALL toggle RB and decrement Count.
- DataOut for that read SHALL still present the old bank's data.
REQ-026 Reads while DataOutEnable is low SHALL NOT change RB or Count; DataOut content is then don't-care.
REQ-027 When a bank completes and a bank is released in the same cycle, Count SHALL be unchanged and both WB and RB SHALL toggle.
REQ-028 DataOutColor and DataOutEob SHALL be combinational selects of the per-bank registers by RB.
REQ-029 DataInit SHALL take priority over a simultaneous write or read:
- Count=0, WB=RB=0;
- running EOB = 0, per-bank EOB and color = 0;
- RAM contents are not cleared.

Reset
REQ-030 While rst is high, the following SHALL be held:
- Count=0, WB=0, RB=0;
- DataInIdle=1, DataOutEnable=0;
- DataOut=0, DataOutColor=0, DataOutEob=0.
REQ-031 Reset mid-block SHALL discard the partial write bank and any unread banks; the first write after reset SHALL go to bank 0.

Verification
REQ-032 Write block with value = natural index + 100, color 2, then read zigzag addresses 0..63:
- DataOut sequence starts 100, 101, 108, 116, 109, 102;
- DataOutColor=2 and DataOutEob=64.
REQ-033 Write an all-zero block except natural index 9 = -5:
- DataOutEob=5 (ZZINV(9)=4);
- reading zigzag 4 returns 0xFFFB.
REQ-034 Write two blocks with no reads:
- DataInIdle=0 and a third-block write is ignored;
- after reading the first block through address 63, DataInIdle=1 and the second block reads intact.
REQ-035 With one block stored, issue the write of index 63 of block 2 in the same cycle as the read of address 63 of block 1:
- Count stays 1;
- RB and WB both toggle;
- block 2 reads correctly.
REQ-036 Assert DataInit, then rst, mid-block after 30 writes:
- DataOutEnable=0, DataOutEob=0;
- a subsequent full block writes to and reads from bank 0 correctly.
